// File: rtl/cfu_issue.sv
// cfu_issue: issues custom-0 instructions to the CFU from held operand copies and returns the result with rd.
// Latency: response valid 2 cycles after accept plus one per stall cycle; an illegal opcode responds after 1 cycle.
// Backpressure: accepts in IDLE or while the pending response drains; CFU_TIMEOUT_EN aborts stalls after TIMEOUT_CYCLES.
module cfu_issue #(
    parameter logic [6:0]  OPCODE         = 7'b0001011,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_insn_i,
    input  logic [31:0] req_src1_i,
    input  logic [31:0] req_src2_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [4:0]  resp_rd_o,
    output logic [31:0] resp_data_o,
    output logic        resp_err_o,
    output logic        busy_o,
    output logic        cfu_en_o,
    output logic [2:0]  cfu_funct3_o,
    output logic [6:0]  cfu_funct7_o,
    output logic [31:0] cfu_src1_o,
    output logic [31:0] cfu_src2_o,
    input  logic        cfu_stall_i,
    input  logic [31:0] cfu_rslt_i
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("cfu_issue: TIMEOUT_CYCLES must be at least 2");
    end

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [6:0]  funct7_q, funct7_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        resp_valid_q, cfu_en_q, busy_q;
    logic        accept, legal;

    // Register-address fields are not needed; the CPU supplies operand values directly.
    logic unused_insn;
    assign unused_insn = ^req_insn_i[24:15];

    assign req_ready_o = (state_q == IDLE) || (state_q == RESP && resp_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign legal       = (req_insn_i[6:0] == OPCODE);

`ifdef CFU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          expired;
    assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        funct7_d = funct7_q;
        rd_d     = rd_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        data_d   = data_q;
        err_d    = err_q;
`ifdef CFU_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    funct3_d = req_insn_i[14:12];
                    funct7_d = req_insn_i[31:25];
                    rd_d     = req_insn_i[11:7];
                    src1_d   = req_src1_i;
                    src2_d   = req_src2_i;
                    if (legal) begin
                        state_d = EXEC;
`ifdef CFU_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = RESP;
                        data_d  = 32'h0;
                        err_d   = 1'b1;
                    end
                end else if (state_q == RESP && resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                // A completing cycle wins over timeout expiry.
                if (!cfu_stall_i) begin
                    data_d  = cfu_rslt_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
`ifdef CFU_TIMEOUT_EN
                else if (expired) begin
                    data_d  = 32'h0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            funct3_q     <= '0;
            funct7_q     <= '0;
            rd_q         <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            cfu_en_q     <= 1'b0;
            busy_q       <= 1'b0;
`ifdef CFU_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            funct7_q     <= funct7_d;
            rd_q         <= rd_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            data_q       <= data_d;
            err_q        <= err_d;
            resp_valid_q <= (state_d == RESP);
            cfu_en_q     <= (state_d == EXEC);
            busy_q       <= (state_d != IDLE);
`ifdef CFU_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_rd_o    = rd_q;
    assign resp_data_o  = data_q;
    assign resp_err_o   = err_q;
    assign busy_o       = busy_q;
    assign cfu_en_o     = cfu_en_q;
    assign cfu_funct3_o = funct3_q;
    assign cfu_funct7_o = funct7_q;
    assign cfu_src1_o   = src1_q;
    assign cfu_src2_o   = src2_q;
endmodule

// File: tb/tb_cfu_issue.sv
// Bench for cfu_issue: directed scenarios followed by randomized traffic against a transaction-level model.
module tb_cfu_issue;
    localparam logic [6:0] OPC = 7'b0001011;

    logic        clk = 1'b0;
    logic        rst_i, req_valid_i, req_ready_o, resp_valid_o, resp_ready_i;
    logic [31:0] req_insn_i, req_src1_i, req_src2_i, resp_data_o;
    logic [4:0]  resp_rd_o;
    logic        resp_err_o, busy_o, cfu_en_o, cfu_stall_i;
    logic [2:0]  cfu_funct3_o;
    logic [6:0]  cfu_funct7_o;
    logic [31:0] cfu_src1_o, cfu_src2_o, cfu_rslt_i;

    always #5 clk = ~clk;

    cfu_issue #(.OPCODE(OPC), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_insn_i(req_insn_i),
        .req_src1_i(req_src1_i), .req_src2_i(req_src2_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_rd_o(resp_rd_o),
        .resp_data_o(resp_data_o), .resp_err_o(resp_err_o), .busy_o(busy_o),
        .cfu_en_o(cfu_en_o), .cfu_funct3_o(cfu_funct3_o), .cfu_funct7_o(cfu_funct7_o),
        .cfu_src1_o(cfu_src1_o), .cfu_src2_o(cfu_src2_o),
        .cfu_stall_i(cfu_stall_i), .cfu_rslt_i(cfu_rslt_i)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
        return {f7, 10'h155, f3, rd, op};
    endfunction

    // Stand-in CFU function, also used by the model to predict results.
    function automatic logic [31:0] cfu_fn(input logic [2:0] f3, input logic [6:0] f7,
                                           input logic [31:0] a, input logic [31:0] b);
        return (a + b) ^ {f7, 22'h0, f3};
    endfunction

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] s1;
        logic [31:0] s2;
    } txn_t;

    txn_t q[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_a, exp_b;
        logic [6:0]  op;
        int          n, stall_run;
        logic        lg, exp_rdy;
        txn_t        t;

        rst_i = 1'b1; req_valid_i = 1'b0; req_insn_i = '0; req_src1_i = '0; req_src2_i = '0;
        resp_ready_i = 1'b1; cfu_stall_i = 1'b0; cfu_rslt_i = '0;
        tick(); tick();
        check("rst_valid", resp_valid_o, 0);
        check("rst_en", cfu_en_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_data", resp_data_o, 0);
        check("rst_rd", resp_rd_o, 0);
        check("rst_err", resp_err_o, 0);
        check("rst_f3", cfu_funct3_o, 0);
        check("rst_f7", cfu_funct7_o, 0);
        check("rst_src1", cfu_src1_o, 0);
        check("rst_src2", cfu_src2_o, 0);
        rst_i = 1'b0;
        settle();
        check("rst_ready", req_ready_o, 1);

        // Basic non-stalling request.
        req_valid_i = 1'b1; req_insn_i = mk(7'd0, 3'd0, 5'd3, OPC);
        req_src1_i = 32'd5; req_src2_i = 32'd7; cfu_rslt_i = 32'd12;
        tick();
        req_valid_i = 1'b0;
        check("t1_en", cfu_en_o, 1);
        check("t1_src1", cfu_src1_o, 5);
        check("t1_src2", cfu_src2_o, 7);
        check("t1_f3", cfu_funct3_o, 0);
        check("t1_valid_early", resp_valid_o, 0);
        check("t1_busy", busy_o, 1);
        tick();
        check("t1_valid", resp_valid_o, 1);
        check("t1_en_off", cfu_en_o, 0);
        check("t1_rd", resp_rd_o, 3);
        check("t1_data", resp_data_o, 12);
        check("t1_err", resp_err_o, 0);
        tick();
        check("t1_idle", resp_valid_o, 0);
        check("t1_idle_busy", busy_o, 0);

        // Four stall cycles, operands held throughout.
        req_valid_i = 1'b1; req_insn_i = mk(7'h15, 3'd1, 5'd9, OPC);
        req_src1_i = 32'h1111_2222; req_src2_i = 32'h3333_4444; cfu_stall_i = 1'b1;
        tick();
        req_valid_i = 1'b0; req_src1_i = $urandom; req_src2_i = $urandom;
        for (int i = 0; i < 5; i++) begin
            check("t2_en", cfu_en_o, 1);
            check("t2_f3", cfu_funct3_o, 1);
            check("t2_f7", cfu_funct7_o, 7'h15);
            check("t2_src1", cfu_src1_o, 32'h1111_2222);
            check("t2_src2", cfu_src2_o, 32'h3333_4444);
            check("t2_valid_early", resp_valid_o, 0);
            cfu_stall_i = (i < 4);
            cfu_rslt_i  = (i < 4) ? $urandom : 32'hCAFE_0001;
            tick();
        end
        check("t2_valid", resp_valid_o, 1);
        check("t2_data", resp_data_o, 32'hCAFE_0001);
        check("t2_rd", resp_rd_o, 9);
        tick();

        // Illegal opcode: immediate error response, CFU never enabled.
        req_valid_i = 1'b1; req_insn_i = mk(7'd0, 3'd0, 5'd17, 7'b0110011);
        tick();
        req_valid_i = 1'b0;
        check("t3_en", cfu_en_o, 0);
        check("t3_valid", resp_valid_o, 1);
        check("t3_err", resp_err_o, 1);
        check("t3_data", resp_data_o, 0);
        check("t3_rd", resp_rd_o, 17);
        tick();
        check("t3_idle", resp_valid_o, 0);
        check("t3_en_after", cfu_en_o, 0);

        // Response backpressure then back-to-back accept.
        exp_a = cfu_fn(3'd2, 7'd3, 32'd100, 32'd200);
        exp_b = cfu_fn(3'd5, 7'd1, 32'd1000, 32'd2000);
        req_valid_i = 1'b1; req_insn_i = mk(7'd3, 3'd2, 5'd4, OPC);
        req_src1_i = 32'd100; req_src2_i = 32'd200; cfu_rslt_i = exp_a; resp_ready_i = 1'b0;
        tick();
        req_valid_i = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_valid", resp_valid_o, 1);
            check("t4_hold_rd", resp_rd_o, 4);
            check("t4_hold_data", resp_data_o, exp_a);
            req_valid_i = 1'b1; req_insn_i = mk(7'd1, 3'd5, 5'd6, OPC);
            req_src1_i = 32'd1000; req_src2_i = 32'd2000; cfu_rslt_i = $urandom;
            settle();
            check("t4_hold_ready", req_ready_o, 0);
            tick();
        end
        resp_ready_i = 1'b1; cfu_rslt_i = exp_b;
        settle();
        check("t4_ready_rise", req_ready_o, 1);
        check("t4_last_data", resp_data_o, exp_a);
        tick();
        req_valid_i = 1'b0;
        check("t4_b_en", cfu_en_o, 1);
        check("t4_b_src1", cfu_src1_o, 1000);
        check("t4_b_valid", resp_valid_o, 0);
        tick();
        check("t4_b_resp", resp_valid_o, 1);
        check("t4_b_data", resp_data_o, exp_b);
        check("t4_b_rd", resp_rd_o, 6);
        tick();

        // Reset while stalled in EXEC drops the request.
        req_valid_i = 1'b1; req_insn_i = mk(7'd0, 3'd0, 5'd8, OPC); cfu_stall_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();
        check("t5_en_pre", cfu_en_o, 1);
        rst_i = 1'b1;
        tick();
        check("t5_en", cfu_en_o, 0);
        check("t5_valid", resp_valid_o, 0);
        check("t5_busy", busy_o, 0);
        settle();
        check("t5_ready", req_ready_o, 1);
        rst_i = 1'b0; cfu_stall_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_no_resp", resp_valid_o, 0);
        end

        // Permanently stalled CFU.
        req_valid_i = 1'b1; req_insn_i = mk(7'd0, 3'd0, 5'd2, OPC); cfu_stall_i = 1'b1;
        cfu_rslt_i = 32'hDEAD_BEEF;
        tick();
        req_valid_i = 1'b0;
        n = 0;
        while (cfu_en_o && n < 100) begin
            n++;
            tick();
        end
`ifdef CFU_TIMEOUT_EN
        check("t6_exec_cycles", n, 8);
        check("t6_valid", resp_valid_o, 1);
        check("t6_err", resp_err_o, 1);
        check("t6_data", resp_data_o, 0);
        cfu_stall_i = 1'b0;
        tick();
`else
        check("t6_exec_cycles", n, 100);
        check("t6_no_resp", resp_valid_o, 0);
        check("t6_busy", busy_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; cfu_stall_i = 1'b0;
`endif
        check("t6_after_valid", busy_o, resp_valid_o);

        // Randomized traffic; the last cycles drain the pipeline.
        stall_run = 0;
        for (int cyc = 0; cyc < 430; cyc++) begin
            check("r_busy", busy_o, (q.size() != 0));
            if (cfu_en_o) begin
                if (q.size() == 0) begin
                    check("r_en_orphan", 1, 0);
                end else begin
                    check("r_en_legal", q[0].err, 0);
                    check("r_f3", cfu_funct3_o, q[0].f3);
                    check("r_f7", cfu_funct7_o, q[0].f7);
                    check("r_src1", cfu_src1_o, q[0].s1);
                    check("r_src2", cfu_src2_o, q[0].s2);
                end
            end
            cfu_rslt_i = cfu_fn(cfu_funct3_o, cfu_funct7_o, cfu_src1_o, cfu_src2_o);
            if (cyc < 400) begin
                req_valid_i = ($urandom_range(0, 2) != 0);
                lg = ($urandom_range(0, 3) != 0);
                op = 7'($urandom);
                if (lg) op = OPC;
                else if (op == OPC) op = op ^ 7'h1;
                req_insn_i = $urandom;
                req_insn_i[6:0] = op;
                req_src1_i = $urandom;
                req_src2_i = $urandom;
                cfu_stall_i = (stall_run < 3) && ($urandom_range(0, 2) == 0);
                resp_ready_i = ($urandom_range(0, 3) != 0);
            end else begin
                req_valid_i = 1'b0; cfu_stall_i = 1'b0; resp_ready_i = 1'b1;
            end
            stall_run = cfu_stall_i ? stall_run + 1 : 0;
            settle();
            exp_rdy = (q.size() == 0) || (resp_valid_o && resp_ready_i);
            check("r_ready", req_ready_o, exp_rdy);
            if (resp_valid_o && resp_ready_i) begin
                if (q.size() == 0) begin
                    check("r_spurious_resp", 1, 0);
                end else begin
                    t = q.pop_front();
                    check("r_rd", resp_rd_o, t.rd);
                    check("r_data", resp_data_o, t.data);
                    check("r_err", resp_err_o, t.err);
                end
            end
            if (req_valid_i && req_ready_o) begin
                t.rd  = req_insn_i[11:7];
                t.f3  = req_insn_i[14:12];
                t.f7  = req_insn_i[31:25];
                t.s1  = req_src1_i;
                t.s2  = req_src2_i;
                t.err = (req_insn_i[6:0] != OPC);
                t.data = t.err ? 32'h0 : cfu_fn(t.f3, t.f7, t.s1, t.s2);
                q.push_back(t);
            end
            tick();
        end
        check("r_drained", q.size(), 0);
        check("r_final_busy", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
